fp_add_hs: RTL and testbench
============================

Name: fp_add_hs

Overview:
- Parameterised IEEE-754-style floating-point adder behind a two-phase request / one-cycle-pulse acknowledge handshake.
- Defaults give binary32 (1 sign, 8 exponent, 23 fraction bits).
- Sits between a producer that toggles `req` per operation and a consumer that waits for `ack`.
- Multi-cycle, one operation in flight, fixed latency.

Parameters:
- MSB, 31: index of the sign bit; word width is MSB+1.
- FMSB, 22: index of the fraction MSB; fraction is [FMSB:0], exponent is [MSB-1:FMSB+1].
- Exponent width EW = MSB-FMSB-1 (derived); bias = 2^(EW-1)-1.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  synchronous reset, active-high (1 = reset), sampled on the clk rising edge.
- enable  in  1  block enable; 0 = idle/abort.
- req  in  1  two-phase request; every toggle starts one operation.
- rx_data_1  in  MSB+1  operand A.
- rx_data_2  in  MSB+1  operand B.
- tx_data  out  MSB+1  registered sum, held until the next result.
- ack  out  1  one-cycle pulse when tx_data is updated.

Behaviour:
- Reset values: tx_data=0, ack=0, FSM=IDLE, req_q=0.
- req_q <= req every cycle, regardless of state or enable, so no spurious start occurs on enable rise.
- Start condition: state IDLE, enable=1 and req!=req_q at edge N. Both operands are captured at edge N.
- FSM sequence:
  - IDLE→ALIGN at edge N.
  - ALIGN: unpack, handle special cases, swap so |A|>=|B|, right-shift the smaller mantissa by the exponent difference, keep guard/round/sticky.
  - ADD: add or subtract mantissas per signs.
  - NORM: leading-zero count plus a left shift in one cycle, or a right shift by 1 on carry-out; adjust the exponent.
  - PACK: round and pack.
  - Transition to IDLE at edge N+4, with tx_data written and ack=1 during the cycle after edge N+4.
  - Latency is exactly 4 edges after the start edge.
- ack returns to 0 on the next edge.
- Toggles of req while not in IDLE are ignored. req_q still tracks req, so no queued request results.
- enable=0 in any state: go to IDLE at the next edge, ack=0, tx_data held, the in-flight operation is discarded.
- Synchronous reset mid-operation: all reset values restored at that edge.
- Denormal inputs (exp=0) are treated as signed zero. Results below the minimum normal flush to zero with the result sign.
- Special cases:
  - NaN in → canonical NaN: sign 0, exp all ones, frac MSB 1, rest 0 (0x7FC00000 for binary32).
  - Inf + (-Inf) → canonical NaN.
  - Inf + finite → that Inf.
  - x + (-x) exact zero → +0.
  - Zero operand → the other operand.
- Overflow (exponent reaches all ones) → signed Inf.
- Default rounding: truncate toward zero (guard/round/sticky discarded).

Optional Feature:
- Macro FP_ADD_RNE_EN.
- Defined: round-to-nearest-even using guard/round/sticky in PACK. A mantissa carry on rounding increments the exponent and may overflow to Inf.
- Undefined: truncation as above.
- Latency is unchanged in both cases.

Decomposition:
- Package fp_add_pkg holds:
  - state enum (IDLE, ALIGN, ADD, NORM, PACK);
  - functions for the derived widths EW and bias;
  - canonical NaN / Inf constants as functions of MSB and FMSB.
- One sub-module, fp_lzc: a parameterised combinational leading-zero counter used in NORM.

Test Plan:
- 0x3F800000 + 0x3F800000, req 0→1 → ack pulses exactly 4 edges after the start edge, width 1 cycle, tx_data=0x40000000.
- 0x3FC00000 + 0xBF000000 (1.5 + -0.5) → 0x3F800000; then 0x3F800000 + 0xBF800000 → 0x00000000.
- 0x7F800000 + 0xFF800000 → 0x7FC00000; 0x7F800000 + 0x3F800000 → 0x7F800000; 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- 0x3F800000 + 0x33C00000 (1 + 1.5·2^-24) → 0x3F800000 truncating; 0x3F800001 with FP_ADD_RNE_EN.
- Toggle req twice within 2 cycles → exactly one ack. Drop enable at edge N+2 → no ack, tx_data unchanged. Re-enable → no spurious start.
- Assert rstn mid-operation → tx_data=0 and ack=0 at that edge. 100 random operand pairs with exponents 107..157 compared against a reference model.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and format helpers for the handshaked floating-point adder.
// Widths and special encodings are derived from the sign / fraction-MSB indices.
package fp_add_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        PACK  = 3'd4
    } fp_state_e;

    function automatic int unsigned fp_ew(input int unsigned msb, input int unsigned fmsb);
        return msb - fmsb - 1;
    endfunction

    function automatic int unsigned fp_bias(input int unsigned msb, input int unsigned fmsb);
        return (32'd1 << (fp_ew(msb, fmsb) - 1)) - 32'd1;
    endfunction

    // Positive infinity in the low msb+1 bits of a 64-bit word.
    function automatic logic [63:0] fp_inf(input int unsigned msb, input int unsigned fmsb);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = fmsb + 1; i < msb; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [63:0] fp_qnan(input int unsigned msb, input int unsigned fmsb);
        logic [63:0] r;
        r       = fp_inf(msb, fmsb);
        r[fmsb] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc
    import fp_add_pkg::*;
#(
    parameter int unsigned W  = 27,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        logic found;
        found = 1'b0;
        cnt_o = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (!found && d_i[W-1-i]) begin
                cnt_o = CW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_hs.sv
// Floating-point adder behind a two-phase req / one-cycle ack handshake, fixed 4-edge latency.
// Define FP_ADD_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp_add_hs
    import fp_add_pkg::*;
#(
    parameter int unsigned MSB  = 31,
    parameter int unsigned FMSB = 22
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enable,
    input  logic         req,
    input  logic [MSB:0] rx_data_1,
    input  logic [MSB:0] rx_data_2,
    output logic [MSB:0] tx_data,
    output logic         ack
);

    localparam int unsigned EW  = fp_ew(MSB, FMSB);
    localparam int unsigned F   = FMSB + 1;
    localparam int unsigned MW  = F + 4;     // hidden + fraction + guard/round/sticky
    localparam int unsigned CW  = $clog2(MW + 1);
    localparam int unsigned FW1 = F + 1;

    localparam logic [63:0]    INF64     = fp_inf(MSB, FMSB);
    localparam logic [63:0]    QNAN64    = fp_qnan(MSB, FMSB);
    localparam logic [MSB-1:0] INF_MAG   = INF64[MSB-1:0];
    localparam logic [MSB:0]   QNAN      = QNAN64[MSB:0];
    localparam logic [MSB-1:0] ZERO_MAG  = '0;
    localparam logic [EW-1:0]  EXP_ONES  = '1;
    localparam logic [MW-1:0]  MANT_ONES = '1;

    fp_state_e     state_q, state_d;
    logic          req_q, req_d;
    logic [MSB:0]  a_q, a_d, b_q, b_d;
    logic          spec_q, spec_d;
    logic [MSB:0]  spec_val_q, spec_val_d;
    logic          sign_q, sign_d, sub_q, sub_d;
    logic [MW-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [MW:0]   sum_q, sum_d;
    logic [MW-1:0] mant_q, mant_d;
    logic          zero_q, zero_d, inf_q, inf_d;
    logic [MSB:0]  tx_q, tx_d;
    logic          ack_q, ack_d;

    logic          al_spec, al_sign, al_sub;
    logic [MSB:0]  al_spec_val;
    logic [MW-1:0] al_ma, al_mb;
    logic [EW-1:0] al_exp;
    logic [CW-1:0] lz;
    logic [MW-1:0] nm_mant;
    logic [EW-1:0] nm_exp;
    logic          nm_zero, nm_inf, nm_sign;
    logic [MSB:0]  pk_data;

    always_comb begin : align_c
        logic [EW-1:0] ea, eb, ediff;
        logic [F-1:0]  fa, fb;
        logic          za, zb, infa, infb, nana, nanb;
        logic [MSB:0]  big, sml;
        logic [MW-1:0] mfull, mshift, lost;
        ea    = a_q[MSB-1:FMSB+1];
        eb    = b_q[MSB-1:FMSB+1];
        fa    = a_q[FMSB:0];
        fb    = b_q[FMSB:0];
        za    = (ea == '0);
        zb    = (eb == '0);
        infa  = (ea == EXP_ONES) && (fa == '0);
        infb  = (eb == EXP_ONES) && (fb == '0);
        nana  = (ea == EXP_ONES) && (fa != '0);
        nanb  = (eb == EXP_ONES) && (fb != '0);
        big   = (a_q[MSB-1:0] >= b_q[MSB-1:0]) ? a_q : b_q;
        sml   = (a_q[MSB-1:0] >= b_q[MSB-1:0]) ? b_q : a_q;
        ediff = big[MSB-1:FMSB+1] - sml[MSB-1:FMSB+1];
        // Bits shifted out below the sticky position collapse into sticky.
        mfull  = {1'b1, sml[FMSB:0], 3'b000};
        mshift = mfull >> ediff;
        lost   = mfull & ~(MANT_ONES << ediff);
        al_ma  = {1'b1, big[FMSB:0], 3'b000};
        al_mb  = {mshift[MW-1:1], mshift[0] | (|lost)};
        al_exp = big[MSB-1:FMSB+1];
        al_sign = big[MSB];
        al_sub  = a_q[MSB] ^ b_q[MSB];
        al_spec     = 1'b1;
        al_spec_val = '0;
        if (nana || nanb || (infa && infb && (a_q[MSB] != b_q[MSB]))) begin
            al_spec_val = QNAN;
        end else if (infa) begin
            al_spec_val = a_q;
        end else if (infb) begin
            al_spec_val = b_q;
        end else if (za && zb) begin
            al_spec_val = {a_q[MSB] & b_q[MSB], ZERO_MAG};
        end else if (za) begin
            al_spec_val = b_q;
        end else if (zb) begin
            al_spec_val = a_q;
        end else begin
            al_spec = 1'b0;
        end
    end

    fp_lzc #(.W(MW), .CW(CW)) u_lzc (
        .d_i  (sum_q[MW-1:0]),
        .cnt_o(lz)
    );

    always_comb begin : norm_c
        logic [EW-1:0] exp_inc;
        exp_inc = exp_q + EW'(1);
        nm_mant = mant_q;
        nm_exp  = exp_q;
        nm_zero = 1'b0;
        nm_inf  = 1'b0;
        nm_sign = sign_q;
        if (sum_q[MW]) begin
            nm_mant = {sum_q[MW:2], sum_q[1] | sum_q[0]};
            nm_exp  = exp_inc;
            nm_inf  = (exp_inc == EXP_ONES);
        end else if (sum_q == '0) begin
            nm_zero = 1'b1;
            nm_sign = 1'b0;
        end else begin
            nm_mant = sum_q[MW-1:0] << lz;
            nm_exp  = exp_q - EW'(lz);
            nm_zero = (32'(exp_q) <= 32'(lz));
        end
    end

    always_comb begin : pack_c
        logic [F-1:0]  frac;
        logic [EW-1:0] ex;
`ifdef FP_ADD_RNE_EN
        logic          rnd_up;
        logic [F:0]    frac_rnd;
`else
        logic          unused_grs;
`endif
        frac = mant_q[MW-2:3];
        ex   = exp_q;
`ifdef FP_ADD_RNE_EN
        rnd_up   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        frac_rnd = {1'b0, frac} + FW1'(rnd_up);
        frac     = frac_rnd[F-1:0];
        ex       = exp_q + EW'(frac_rnd[F]);
`else
        unused_grs = |mant_q[2:0];
`endif
        if (spec_q) begin
            pk_data = spec_val_q;
        end else if (zero_q) begin
            pk_data = {sign_q, ZERO_MAG};
        end else if (inf_q || (ex == EXP_ONES)) begin
            pk_data = {sign_q, INF_MAG};
        end else begin
            pk_data = {sign_q, ex, frac};
        end
    end

    always_comb begin : fsm_c
        state_d    = state_q;
        req_d      = req;
        a_d        = a_q;
        b_d        = b_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        exp_d      = exp_q;
        sum_d      = sum_q;
        mant_d     = mant_q;
        zero_d     = zero_q;
        inf_d      = inf_q;
        tx_d       = tx_q;
        ack_d      = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != req_q) begin
                        a_d     = rx_data_1;
                        b_d     = rx_data_2;
                        state_d = ALIGN;
                    end
                end
                ALIGN: begin
                    spec_d     = al_spec;
                    spec_val_d = al_spec_val;
                    sign_d     = al_sign;
                    sub_d      = al_sub;
                    ma_d       = al_ma;
                    mb_d       = al_mb;
                    exp_d      = al_exp;
                    state_d    = ADD;
                end
                ADD: begin
                    sum_d   = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                                    : ({1'b0, ma_q} + {1'b0, mb_q});
                    state_d = NORM;
                end
                NORM: begin
                    mant_d  = nm_mant;
                    exp_d   = nm_exp;
                    zero_d  = nm_zero;
                    inf_d   = nm_inf;
                    sign_d  = nm_sign;
                    state_d = PACK;
                end
                PACK: begin
                    tx_d    = pk_data;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            exp_q      <= '0;
            sum_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            tx_q       <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            a_q        <= a_d;
            b_q        <= b_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            exp_q      <= exp_d;
            sum_q      <= sum_d;
            mant_q     <= mant_d;
            zero_q     <= zero_d;
            inf_q      <= inf_d;
            tx_q       <= tx_d;
            ack_q      <= ack_d;
        end
    end

    assign tx_data = tx_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_fp_add_hs.sv
// Bench for fp_add_hs (binary32): directed handshake/special cases plus random operands
// against an exact-integer reference adder; follows FP_ADD_RNE_EN for rounding.
module tb_fp_add_hs;

    logic        clk = 1'b0;
    logic        rstn, enable, req, ack;
    logic [31:0] rx_data_1, rx_data_2, tx_data;
    logic [31:0] last_exp;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fp_add_hs #(.MSB(31), .FMSB(22)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .req      (req),
        .rx_data_1(rx_data_1),
        .rx_data_2(rx_data_2),
        .tx_data  (tx_data),
        .ack      (ack)
    );

    // Exact sum of two normal binary32 values as scaled integers, then rounded once.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int           ea, eb, emin, p, e;
        logic [127:0] va, vb, mag, m;
        logic         s;
`ifdef FP_ADD_RNE_EN
        logic [127:0] rem, half;
`endif
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        emin = (ea < eb) ? ea : eb;
        va   = {104'd0, 1'b1, a[22:0]} << (ea - emin);
        vb   = {104'd0, 1'b1, b[22:0]} << (eb - emin);
        if (a[31] == b[31]) begin
            mag = va + vb; s = a[31];
        end else if (va >= vb) begin
            mag = va - vb; s = a[31];
        end else begin
            mag = vb - va; s = b[31];
        end
        if (mag == 128'd0) return 32'h0000_0000;
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = emin + p - 23;
        if (p >= 23) begin
            m = mag >> (p - 23);
`ifdef FP_ADD_RNE_EN
            if (p >= 24) begin
                rem  = mag - (m << (p - 23));
                half = 128'd1 << (p - 24);
                if ((rem > half) || ((rem == half) && m[0])) m = m + 128'd1;
                if (m[24]) begin
                    m = m >> 1;
                    e = e + 1;
                end
            end
`endif
        end else begin
            m = mag << (23 - p);
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    // Issues one request and reports edges from the start edge to the ack pulse (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] d);
        rx_data_1 = a;
        rx_data_2 = b;
        req       = ~req;
        lat       = -1;
        d         = 32'hxxxx_xxxx;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                lat = i - 1;
                d   = tx_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1; enable = 1'b0; req = 1'b0;
        rx_data_1 = '0; rx_data_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_data !== 32'h0) begin
            errors++; $display("FAIL reset_tx: got %h expected %h", tx_data, 32'h0);
        end
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack: got %b expected 0", ack);
        end
        rstn = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        last_exp = 32'h0;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] d;
        run_op(32'h3F80_0000, 32'h3F80_0000, lat, d);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        checks++;
        if (d !== 32'h4000_0000) begin
            errors++; $display("FAIL basic_data: got %h expected %h", d, 32'h4000_0000);
        end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL basic_ack_width: got %b expected 0", ack);
        end
        last_exp = 32'h4000_0000;
    endtask

    task automatic test_sub();
        int lat; logic [31:0] d;
        run_op(32'h3FC0_0000, 32'hBF00_0000, lat, d);
        checks++;
        if (lat != 4 || d !== 32'h3F80_0000) begin
            errors++; $display("FAIL sub_mixed: got %h lat %0d expected %h lat 4", d, lat, 32'h3F80_0000);
        end
        run_op(32'h3F80_0000, 32'hBF80_0000, lat, d);
        checks++;
        if (lat != 4 || d !== 32'h0000_0000) begin
            errors++; $display("FAIL sub_cancel: got %h lat %0d expected %h lat 4", d, lat, 32'h0);
        end
        last_exp = 32'h0;
    endtask

    task automatic test_special();
        logic [31:0] ta[7] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h7FC1_2345,
                               32'h0000_0000, 32'hC049_0FDB, 32'h8000_0000};
        logic [31:0] tb[7] = '{32'hFF80_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h3F80_0000,
                               32'h4049_0FDB, 32'h0000_0000, 32'h8000_0000};
        logic [31:0] te[7] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000,
                               32'h4049_0FDB, 32'hC049_0FDB, 32'h8000_0000};
        int lat; logic [31:0] d;
        for (int k = 0; k < 7; k++) begin
            run_op(ta[k], tb[k], lat, d);
            checks++;
            if (lat != 4 || d !== te[k]) begin
                errors++;
                $display("FAIL special_%0d: %h+%h got %h lat %0d expected %h lat 4",
                         k, ta[k], tb[k], d, lat, te[k]);
            end
        end
        last_exp = 32'h8000_0000;
    endtask

    task automatic test_round();
        int lat; logic [31:0] d; logic [31:0] exp_v;
`ifdef FP_ADD_RNE_EN
        exp_v = 32'h3F80_0001;
`else
        exp_v = 32'h3F80_0000;
`endif
        run_op(32'h3F80_0000, 32'h33C0_0000, lat, d);
        checks++;
        if (lat != 4 || d !== exp_v) begin
            errors++; $display("FAIL round: got %h lat %0d expected %h lat 4", d, lat, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_double_toggle();
        int acks; logic [31:0] got;
        rx_data_1 = 32'h3FC0_0000;
        rx_data_2 = 32'h3FC0_0000;
        req = ~req;
        @(posedge clk); #1;
        req = ~req;
        acks = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                acks++;
                got = tx_data;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++; $display("FAIL double_toggle_acks: got %0d expected 1", acks);
        end
        checks++;
        if (got !== 32'h4040_0000) begin
            errors++; $display("FAIL double_toggle_data: got %h expected %h", got, 32'h4040_0000);
        end
        last_exp = 32'h4040_0000;
    endtask

    task automatic test_enable_drop();
        int acks, lat; logic [31:0] d;
        rx_data_1 = 32'h4000_0000;
        rx_data_2 = 32'h4000_0000;
        req = ~req;
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL abort_acks: got %0d expected 0", acks);
        end
        checks++;
        if (tx_data !== last_exp) begin
            errors++; $display("FAIL abort_hold: got %h expected %h", tx_data, last_exp);
        end
        req = ~req;
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL reenable_spurious: got %0d acks expected 0", acks);
        end
        run_op(32'h4000_0000, 32'h4000_0000, lat, d);
        checks++;
        if (lat != 4 || d !== 32'h4080_0000) begin
            errors++; $display("FAIL reenable_op: got %h lat %0d expected %h lat 4", d, lat, 32'h4080_0000);
        end
        last_exp = 32'h4080_0000;
    endtask

    task automatic test_reset_mid();
        int acks;
        rx_data_1 = 32'h4000_0000;
        rx_data_2 = 32'h3F80_0000;
        req = ~req;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        req  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (tx_data !== 32'h0) begin
            errors++; $display("FAIL midreset_tx: got %h expected %h", tx_data, 32'h0);
        end
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL midreset_ack: got %b expected 0", ack);
        end
        rstn = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL midreset_no_ack: got %0d expected 0", acks);
        end
        last_exp = 32'h0;
    endtask

    task automatic test_random();
        int lat; logic [31:0] a, b, d, e;
        for (int k = 0; k < 100; k++) begin
            a = {1'($urandom), 8'($urandom_range(157, 107)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(157, 107)), 23'($urandom)};
            e = ref_add(a, b);
            run_op(a, b, lat, d);
            checks++;
            if (d !== e) begin
                errors++; $display("FAIL random_%0d: %h+%h got %h expected %h", k, a, b, d, e);
            end
            checks++;
            if (lat != 4) begin
                errors++; $display("FAIL random_lat_%0d: got %0d expected 4", k, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_special();
        test_round();
        test_double_toggle();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
